json_int_array_tx: RTL



---
 rtl/json_int_array_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/json_int_array_tx.sv
// Serializes a stream of binary integers into compact JSON array text ("[12,-5,0]").
// Each element is converted to decimal digits first, then emitted one byte per handshake.
module json_int_array_tx #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1,
  parameter int DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
);

  localparam int NW = $clog2(DIGITS + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {WAIT, CONV, OPEN, SIGN, DIG, SEP, CLOSE} state_t;

  typedef struct packed {
    logic last;
    logic empty;
    logic neg;
  } elem_t;

  state_t                  state, state_nx;
  elem_t                   elem;
  logic                    first;
  logic [WIDTH-1:0]        mag, quo;
  logic [3:0]              rem;
  logic [DIGITS-1:0][3:0]  dbuf;
  logic [NW-1:0]           ndig;
  logic [IW-1:0]           wr_idx, rd_idx;
  logic                    accept, in_neg;

  // Divide-by-constant; the remainder is always < 10 so 4 bits suffice.
  assign quo    = mag / WIDTH'(10);
  assign rem    = 4'(mag - quo * WIDTH'(10));
  assign wr_idx = IW'(ndig);
  assign rd_idx = IW'(ndig - NW'(1));
  assign in_neg = (SIGNED != 0) && in_data[WIDTH-1];
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state)
      WAIT: begin
        in_ready = 1'b1;
        // An empty marker after values closes the open array without a '['.
        if (in_valid) state_nx = in_empty ? (first ? OPEN : CLOSE) : CONV;
      end
      CONV: begin
        if (quo == '0) state_nx = first ? OPEN : (elem.neg ? SIGN : DIG);
      end
      OPEN: begin
        out_valid = 1'b1;
        out_data  = 8'h5B;
        if (out_ready) state_nx = elem.empty ? CLOSE : (elem.neg ? SIGN : DIG);
      end
      SIGN: begin
        out_valid = 1'b1;
        out_data  = 8'h2D;
        if (out_ready) state_nx = DIG;
      end
      DIG: begin
        out_valid = 1'b1;
        out_data  = {4'h3, dbuf[rd_idx]};
        if (out_ready && ndig == NW'(1)) state_nx = elem.last ? CLOSE : SEP;
      end
      SEP: begin
        out_valid = 1'b1;
        out_data  = 8'h2C;
        if (out_ready) state_nx = WAIT;
      end
      CLOSE: begin
        out_valid = 1'b1;
        out_data  = 8'h5D;
        out_last  = 1'b1;
        if (out_ready) state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end

  // Digits are pushed LSB first and popped from the top, so emission is MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem  <= '0;
      first <= 1'b1;
      mag   <= '0;
      ndig  <= '0;
      dbuf  <= '0;
    end else begin
      if (accept) begin
        elem <= '{last: in_last | in_empty, empty: in_empty, neg: in_neg};
        mag  <= in_neg ? -in_data : in_data;
        ndig <= '0;
      end
      if (state == CONV) begin
        mag          <= quo;
        dbuf[wr_idx] <= rem;
        ndig         <= ndig + NW'(1);
      end
      if (state == DIG && out_ready)   ndig  <= ndig - NW'(1);
      if (state == OPEN && out_ready)  first <= 1'b0;
      if (state == CLOSE && out_ready) first <= 1'b1;
    end
  end

endmodule
